// File: rtl/mux_nbit_scan.sv
// N-channel data multiplexer with manual select and auto-scan modes.
// It has a registered valid/ready output stage that honours back-pressure.
module mux_nbit_scan #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] I,
  input  logic [SEL_W-1:0]          S,
  input  logic                      mode,
  input  logic                      start,
  input  logic                      stop,
  output logic [WIDTH-1:0]          Y,
  output logic [SEL_W-1:0]          Y_ch,
  output logic                      Y_valid,
  input  logic                      Y_ready,
  output logic                      scan_wrap,
  output logic                      sel_err
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  state_t             state;
  logic               mode_q;
  logic [SEL_W-1:0]   ptr;
  logic [WIDTH-1:0]   ch [CHANNELS];
  logic               load;
  logic               s_ok;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    assign ch[k] = I[k*WIDTH +: WIDTH];
  end

  // Output stage may take a new beat when it is empty or being drained.
  always_comb begin
    load = !Y_valid || Y_ready;
    s_ok = 32'(S) < CHANNELS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      ptr       <= '0;
      Y         <= '0;
      Y_ch      <= '0;
      Y_valid   <= 1'b0;
      scan_wrap <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      scan_wrap <= 1'b0;
      sel_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (load) Y_valid <= 1'b0;
          if (start && !stop) begin
            mode_q <= mode;
            ptr    <= '0;
            state  <= mode ? SCAN : MANUAL;
          end
        end
        MANUAL, SCAN: begin
          if (stop) begin
            state <= IDLE;
            if (load) Y_valid <= 1'b0;
          end else if (load) begin
            if (mode_q) begin
              Y       <= ch[ptr];
              Y_ch    <= ptr;
              Y_valid <= 1'b1;
              if (ptr == LAST_CH) begin
                ptr       <= '0;
                scan_wrap <= 1'b1;
              end else begin
                ptr <= ptr + 1'b1;
              end
            end else if (s_ok) begin
              Y       <= ch[S];
              Y_ch    <= S;
              Y_valid <= 1'b1;
            end else begin
              Y_valid <= 1'b0;
              sel_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nbit_scan.sv
// Directed bench for mux_nbit_scan.
// Two instances are used: 8 channels (power of two) and 5 channels (non power of two).
module tb_mux_nbit_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [63:0] i8;
  logic [2:0]  s8;
  logic        mode8, start8, stop8, ready8;
  logic [7:0]  y8;
  logic [2:0]  ych8;
  logic        yv8, wrap8, err8;

  logic [39:0] i5;
  logic [2:0]  s5;
  logic        mode5, start5, stop5, ready5;
  logic [7:0]  y5;
  logic [2:0]  ych5;
  logic        yv5, wrap5, err5;

  always #5 clk = ~clk;

  mux_nbit_scan #(.WIDTH(8), .CHANNELS(8), .SEL_W(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .I(i8), .S(s8), .mode(mode8), .start(start8),
    .stop(stop8), .Y(y8), .Y_ch(ych8), .Y_valid(yv8), .Y_ready(ready8),
    .scan_wrap(wrap8), .sel_err(err8)
  );

  mux_nbit_scan #(.WIDTH(8), .CHANNELS(5), .SEL_W(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .I(i5), .S(s5), .mode(mode5), .start(start5),
    .stop(stop5), .Y(y5), .Y_ch(ych5), .Y_valid(yv5), .Y_ready(ready5),
    .scan_wrap(wrap5), .sel_err(err5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({y8, ych8, yv8, wrap8, err8} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset8: got y=%h ch=%0d v=%b w=%b e=%b required all 0", y8, ych8, yv8, wrap8, err8);
    end
    n_checks++;
    if ({y5, ych5, yv5, wrap5, err5} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset5: got y=%h ch=%0d v=%b w=%b e=%b required all 0", y5, ych5, yv5, wrap5, err5);
    end
    start8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    mode8 = 1'b0; s8 = 3'd5; ready8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n_checks++;
    if (yv8 !== 1'b0) begin n_fail++; $display("FAIL man_start_cycle: got v=%b required 0", yv8); end
    tick();
    n_checks++;
    if ({y8, ych8, yv8} !== {8'h15, 3'd5, 1'b1}) begin
      n_fail++; $display("FAIL man_s5: got y=%h ch=%0d v=%b required 15/5/1", y8, ych8, yv8);
    end
    s8 = 3'd2;
    tick();
    n_checks++;
    if ({y8, ych8, yv8} !== {8'h12, 3'd2, 1'b1}) begin
      n_fail++; $display("FAIL man_s2: got y=%h ch=%0d v=%b required 12/2/1", y8, ych8, yv8);
    end
    ready8 = 1'b0; s8 = 3'd6;
    tick();
    n_checks++;
    if ({y8, ych8, yv8} !== {8'h12, 3'd2, 1'b1}) begin
      n_fail++; $display("FAIL man_hold: got y=%h ch=%0d v=%b required 12/2/1", y8, ych8, yv8);
    end
    ready8 = 1'b1;
    tick();
    n_checks++;
    if ({y8, ych8, yv8} !== {8'h16, 3'd6, 1'b1}) begin
      n_fail++; $display("FAIL man_s6: got y=%h ch=%0d v=%b required 16/6/1", y8, ych8, yv8);
    end
    stop8 = 1'b1;
    tick();
    stop8 = 1'b0;
    n_checks++;
    if ({y8, ych8, yv8} !== {8'h16, 3'd6, 1'b0}) begin
      n_fail++; $display("FAIL man_stop: got y=%h ch=%0d v=%b required 16/6/0", y8, ych8, yv8);
    end
    s8 = 3'd1;
    tick();
    n_checks++;
    if ({y8, ych8, yv8} !== {8'h16, 3'd6, 1'b0}) begin
      n_fail++; $display("FAIL man_idle_hold: got y=%h ch=%0d v=%b required 16/6/0", y8, ych8, yv8);
    end
  endtask

  task automatic test_scan();
    mode8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic [2:0] ec;
      logic [7:0] ey;
      logic       ew;
      tick();
      ec = 3'(i % 8);
      ey = 8'h10 + 8'(i % 8);
      ew = (i == 7);
      n_checks++;
      if ({y8, ych8, yv8, wrap8} !== {ey, ec, 1'b1, ew}) begin
        n_fail++;
        $display("FAIL scan_beat%0d: got y=%h ch=%0d v=%b w=%b required %h/%0d/1/%b", i, y8, ych8, yv8, wrap8, ey, ec, ew);
      end
    end
    stop8 = 1'b1;
    tick();
    stop8 = 1'b0;
    n_checks++;
    if (yv8 !== 1'b0) begin n_fail++; $display("FAIL scan_stop: got v=%b required 0", yv8); end
  endtask

  task automatic test_backpressure();
    mode8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (ych8 !== 3'(i)) begin n_fail++; $display("FAIL bp_pre%0d: got ch=%0d required %0d", i, ych8, i); end
    end
    ready8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({y8, ych8, yv8} !== {8'h13, 3'd3, 1'b1}) begin
        n_fail++; $display("FAIL bp_hold%0d: got y=%h ch=%0d v=%b required 13/3/1", i, y8, ych8, yv8);
      end
    end
    ready8 = 1'b1;
    tick();
    n_checks++;
    if ({y8, ych8} !== {8'h14, 3'd4}) begin
      n_fail++; $display("FAIL bp_release: got y=%h ch=%0d required 14/4", y8, ych8);
    end
    tick();
    n_checks++;
    if (ych8 !== 3'd5) begin n_fail++; $display("FAIL bp_next: got ch=%0d required 5", ych8); end
    stop8 = 1'b1;
    tick();
    stop8 = 1'b0;
    tick();
  endtask

  task automatic test_start_stop();
    mode8 = 1'b0; s8 = 3'd1; start8 = 1'b1; stop8 = 1'b1;
    tick();
    start8 = 1'b0; stop8 = 1'b0;
    n_checks++;
    if (yv8 !== 1'b0) begin n_fail++; $display("FAIL ss_same: got v=%b required 0", yv8); end
    tick();
    n_checks++;
    if (yv8 !== 1'b0) begin n_fail++; $display("FAIL ss_stay_idle: got v=%b required 0", yv8); end
    mode8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    n_checks++;
    if ({y8, ych8, yv8} !== {8'h10, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL ss_scan0: got y=%h ch=%0d v=%b required 10/0/1", y8, ych8, yv8);
    end
    ready8 = 1'b0; stop8 = 1'b1;
    tick();
    stop8 = 1'b0;
    n_checks++;
    if ({y8, ych8, yv8} !== {8'h10, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL ss_stop_held: got y=%h ch=%0d v=%b required 10/0/1", y8, ych8, yv8);
    end
    tick();
    n_checks++;
    if ({y8, ych8, yv8} !== {8'h10, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL ss_idle_held: got y=%h ch=%0d v=%b required 10/0/1", y8, ych8, yv8);
    end
    ready8 = 1'b1;
    tick();
    n_checks++;
    if ({ych8, yv8} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL ss_drained: got ch=%0d v=%b required 0/0", ych8, yv8);
    end
    tick();
    n_checks++;
    if (yv8 !== 1'b0) begin n_fail++; $display("FAIL ss_in_idle: got v=%b required 0", yv8); end
  endtask

  task automatic test_sel_err();
    mode5 = 1'b0; s5 = 3'd6; ready5 = 1'b1; start5 = 1'b1;
    tick();
    start5 = 1'b0;
    n_checks++;
    if (err5 !== 1'b0) begin n_fail++; $display("FAIL se_start: got e=%b required 0", err5); end
    tick();
    n_checks++;
    if ({err5, yv5} !== 2'b10) begin n_fail++; $display("FAIL se_s6: got e=%b v=%b required 1/0", err5, yv5); end
    s5 = 3'd1;
    tick();
    n_checks++;
    if ({err5, yv5, y5, ych5} !== {2'b01, 8'h21, 3'd1}) begin
      n_fail++; $display("FAIL se_s1: got e=%b v=%b y=%h ch=%0d required 0/1/21/1", err5, yv5, y5, ych5);
    end
    s5 = 3'd5;
    tick();
    n_checks++;
    if ({err5, yv5, y5, ych5} !== {2'b10, 8'h21, 3'd1}) begin
      n_fail++; $display("FAIL se_s5: got e=%b v=%b y=%h ch=%0d required 1/0/21/1", err5, yv5, y5, ych5);
    end
    stop5 = 1'b1;
    tick();
    stop5 = 1'b0;
    n_checks++;
    if (err5 !== 1'b0) begin n_fail++; $display("FAIL se_pulse: got e=%b required 0", err5); end
    mode5 = 1'b1; start5 = 1'b1;
    tick();
    start5 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] ec;
      logic [7:0] ey;
      logic       ew;
      tick();
      ec = 3'(i % 5);
      ey = 8'h20 + 8'(i % 5);
      ew = (i == 4);
      n_checks++;
      if ({y5, ych5, yv5, wrap5} !== {ey, ec, 1'b1, ew}) begin
        n_fail++;
        $display("FAIL scan5_beat%0d: got y=%h ch=%0d v=%b w=%b required %h/%0d/1/%b", i, y5, ych5, yv5, wrap5, ey, ec, ew);
      end
    end
    stop5 = 1'b1;
    tick();
    stop5 = 1'b0;
  endtask

  task automatic test_reset_mid();
    mode8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (5) tick();
    n_checks++;
    if ({ych8, yv8} !== {3'd4, 1'b1}) begin
      n_fail++; $display("FAIL rm_pre: got ch=%0d v=%b required 4/1", ych8, yv8);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({y8, ych8, yv8, wrap8, err8} !== 14'h0) begin
      n_fail++; $display("FAIL rm_async: got y=%h ch=%0d v=%b w=%b e=%b required all 0", y8, ych8, yv8, wrap8, err8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({yv8, wrap8, err8} !== 3'b000) begin
      n_fail++; $display("FAIL rm_release: got v=%b w=%b e=%b required 0/0/0", yv8, wrap8, err8);
    end
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    n_checks++;
    if ({y8, ych8, yv8} !== {8'h10, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL rm_resume: got y=%h ch=%0d v=%b required 10/0/1", y8, ych8, yv8);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) i8[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 5; k++) i5[k*8 +: 8] = 8'h20 + 8'(k);
    s8 = '0; mode8 = 1'b0; start8 = 1'b0; stop8 = 1'b0; ready8 = 1'b1;
    s5 = '0; mode5 = 1'b0; start5 = 1'b0; stop5 = 1'b0; ready5 = 1'b1;
    test_reset();
    test_manual();
    test_scan();
    test_backpressure();
    test_start_stop();
    test_sel_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
